// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO register pair and its multiply/divide engine.
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_iter_core.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply and
// restoring shift-subtract divide, one bit per step, with its iteration counter.
module hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]      cnt;
    logic               div_mode;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend in the low half and shifts quotient bits in from the right.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        acc_nxt = {add_sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            if (!trial[WIDTH]) begin
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd     <= is_div ? mag_b : mag_a;
            div_mode <= is_div;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];
    assign last   = (cnt == LAST_CNT);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with handshake, sign handling and atomic commit
// of results from the iterative multiply/divide core.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wen,
    input  logic             waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [2];
    logic             accept;
    logic             commit;
    logic             op_signed;
    logic             op_is_div;
    logic signed [WIDTH-1:0] sa, sb;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic             is_div_q;
    logic             neg_lo_q, neg_hi_q, dbz_q;
    logic [WIDTH-1:0] a_raw_q;

    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_last;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign busy     = (state != ST_IDLE);
    assign op_ready = ~busy;
    assign accept   = op_valid & op_ready;
    assign commit   = (state == ST_FIN);

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sa        = src_a;
    assign sb        = src_b;
    assign a_neg     = op_signed && (sa < 0);
    assign b_neg     = op_signed && (sb < 0);
    assign mag_a     = a_neg ? neg_w(src_a) : src_a;
    assign mag_b     = b_neg ? neg_w(src_b) : src_b;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (core_last) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Product sign drives both halves; for divide the remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q <= op_is_div;
            a_raw_q  <= src_a;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= op_is_div ? a_neg : (a_neg ^ b_neg);
            dbz_q    <= op_is_div && (src_b == '0);
        end
    end

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .load   (accept),
        .step   (state == ST_RUN),
        .is_div (op_is_div),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc_hi (core_hi),
        .acc_lo (core_lo),
        .last   (core_last)
    );

    always_comb begin
        prod     = {core_hi, core_lo};
        prod_neg = ~prod + 1'b1;
        res_hi   = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : core_hi;
        res_lo   = neg_lo_q ? prod_neg[WIDTH-1:0] : core_lo;
        if (is_div_q) begin
            if (dbz_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_hi = neg_hi_q ? neg_w(core_hi) : core_hi;
                res_lo = neg_lo_q ? neg_w(core_lo) : core_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            regs[SEL_LO] <= '0;
            regs[SEL_HI] <= '0;
        end else if (commit) begin
            regs[SEL_LO] <= res_lo;
            regs[SEL_HI] <= res_hi;
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= commit;
            div_by_zero <= commit && is_div_q && dbz_q;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: arithmetic/latency reference model checked every cycle
// plus directed vectors with hand-computed results.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic          clk;
    logic          rstn;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          wen;
    logic          waddr;
    logic [W-1:0]  wdata;
    logic          raddr;
    logic [W-1:0]  rdata;
    logic          busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction semantics.
    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a; dbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         p_dbz;
    logic         m_done = 1'b0, m_dbz = 1'b0;
    int           left = 0;
    bit           checking = 1'b0;

    always @(posedge clk) begin
        bit commit;
        if (!rstn) begin
            m_hi = '0; m_lo = '0; left = 0; m_done = 1'b0; m_dbz = 1'b0;
            checking = 1'b1;
        end else begin
            commit = (left == 1);
            m_done = commit;
            m_dbz  = commit && p_dbz;
            if (commit) begin
                m_hi = p_hi; m_lo = p_lo;
            end else if (wen) begin
                if (waddr) m_hi = wdata; else m_lo = wdata;
            end
            if (left > 0) begin
                left--;
            end else if (op_valid) begin
                model_op(op, src_a, src_b, p_hi, p_lo, p_dbz);
                left = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_busy", busy, left > 0);
            chk("cyc_op_ready", op_ready, left == 0);
            chk("cyc_done", done, m_done);
            chk("cyc_div_by_zero", div_by_zero, m_dbz);
            chk("cyc_rdata", rdata, raddr ? m_hi : m_lo);
        end
    end

    task automatic read_pair(input string name, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        raddr = 1'b1; #1;
        chk({name, "_hi"}, rdata, exp_hi);
        raddr = 1'b0; #1;
        chk({name, "_lo"}, rdata, exp_lo);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dbz);
        int edges;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #2;
        op_valid = 1'b0; op = ~o; src_a = $urandom; src_b = $urandom;
        wait_done(edges);
        chk({name, "_latency"}, edges, 33);
        chk({name, "_dbz"}, div_by_zero, exp_dbz);
        #1;
        read_pair(name, exp_hi, exp_lo);
    endtask

    initial begin
        int edges, cnt;
        rstn = 1'b0; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        wen = 1'b0; waddr = 1'b0; wdata = '0; raddr = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        read_pair("reset", 32'h0, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_op_ready", op_ready, 1'b1);
        chk("reset_done", done, 1'b0);

        wen = 1'b1; waddr = 1'b0; wdata = 32'h12345678;
        @(posedge clk); #2;
        wen = 1'b0;
        read_pair("mtlo", 32'h0, 32'h12345678);

        do_op("mult",      2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        do_op("multu",     2'b01, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0);
        do_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        do_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("div_negb",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op("divu",      2'b11, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0);
        do_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op("divu_zero", 2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1);
        do_op("div_zero",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

        // Direct write on the accept edge lands; the commit later overwrites it.
        op_valid = 1'b1; op = 2'b11; src_a = 32'd7; src_b = 32'd2;
        wen = 1'b1; waddr = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #2;
        op_valid = 1'b0; wen = 1'b0;
        raddr = 1'b1; #1;
        chk("accept_wen_hi", rdata, 32'hAAAA5555);
        raddr = 1'b0;
        wait_done(edges);
        chk("accept_wen_latency", edges, 33);
        #1;
        read_pair("accept_wen_res", 32'h1, 32'h3);

        // Direct write to HI on the FIN edge loses to the commit.
        op_valid = 1'b1; op = 2'b01; src_a = 32'h00010000; src_b = 32'h00030000;
        @(posedge clk); #2;
        op_valid = 1'b0;
        repeat (32) @(posedge clk);
        #2;
        wen = 1'b1; waddr = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("fin_wen_done", done, 1'b1);
        #1;
        wen = 1'b0;
        read_pair("fin_wen", 32'h3, 32'h0);

        // Continuous request: one accept every 34 cycles.
        op_valid = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
        cnt = 0;
        for (int i = 0; i < 102; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        #1;
        op_valid = 1'b0;
        chk("hold_done_count", cnt, 3);
        read_pair("hold", 32'h0, 32'd15);

        // Reset in RUN cycle 10 aborts without a commit.
        op_valid = 1'b1; op = 2'b00; src_a = 32'hFFFFFFFE; src_b = 32'd3;
        @(posedge clk); #2;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        chk("abort_busy", busy, 1'b0);
        read_pair("abort", 32'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
